glyph_renderer: RTL and testbench

Text-mode pixel generator that reads the 27-entry 16x32 glyph ROM. For each VGA pixel coordinate it fetches the character code from the text buffer, addresses the glyph ROM, selects the pixel bit, applies cursor blink inversion and emits a 12-bit RGB colour. It sits between the VGA timing generator / text buffer and the DAC output register.

---
 rtl/glyph_pkg.sv | 26 ++
 rtl/glyph_blink_timer.sv | 33 +++
 rtl/glyph_renderer.sv | 102 ++++++++++
 tb/tb_glyph_renderer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared glyph ROM geometry, character codes and the glyph bit-select helper
// for the text-mode pixel generator.
package glyph_pkg;

  localparam int GLYPH_W    = 16;
  localparam int GLYPH_H    = 32;
  localparam int GLYPH_BITS = 512;
  localparam int NUM_GLYPHS = 27;

  typedef enum logic [4:0] {
    BLANK = 5'd0,
    A = 5'd1,  B = 5'd2,  C = 5'd3,  D = 5'd4,  E = 5'd5,  F = 5'd6,
    G = 5'd7,  H = 5'd8,  I = 5'd9,  J = 5'd10, K = 5'd11, L = 5'd12,
    M = 5'd13, N = 5'd14, O = 5'd15, P = 5'd16, Q = 5'd17, R = 5'd18,
    S = 5'd19, T = 5'd20, U = 5'd21, V = 5'd22, W = 5'd23, X = 5'd24,
    Y = 5'd25, Z = 5'd26
  } glyph_code_e;

  // Rows are 16 bits wide and stacked top to bottom, so {gy,gx} is 16*gy+gx.
  function automatic logic glyph_bit(input logic [GLYPH_BITS-1:0] data,
                                     input logic [3:0] gx,
                                     input logic [4:0] gy);
    return data[{gy, gx}];
  endfunction

endpackage

// File: rtl/glyph_blink_timer.sv
// Cursor blink timer: counts frame starts and toggles the blink phase every
// BLINK_FRAMES frames.
module glyph_blink_timer
  import glyph_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/glyph_renderer.sv
// Text-mode pixel generator: tile lookup, glyph bit select, cursor inversion
// and colour output, two cycles from pixel strobe to colour.
module glyph_renderer
  import glyph_pkg::*;
#(
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h000,
  parameter int          BLINK_FRAMES = 30,
  parameter int          COLS         = 40,
  parameter int          ROWS         = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pix_valid_i,
  input  logic [9:0]   pix_x_i,
  input  logic [9:0]   pix_y_i,
  input  logic         active_i,
  input  logic [5:0]   cursor_col_i,
  input  logic [3:0]   cursor_row_i,
  input  logic         cursor_en_i,
  output logic [9:0]   char_addr_o,
  input  logic [4:0]   char_code_i,
  output logic [9:0]   rom_addr_o,
  input  logic [511:0] rom_data_i,
  output logic [11:0]  rgb_o,
  output logic         pix_valid_o
);

  logic [5:0] col;
  logic [4:0] row;
  logic [9:0] addr_next;
  logic       in_area;
  logic       cursor_hit;
  logic       frame_start;
  logic       blink_phase;

  logic       vld_p0, vld_p1;
  logic [3:0] gx_p0, gx_p1;
  logic [4:0] gy_p0, gy_p1;
  logic       in_area_p0, in_area_p1;
  logic       inv_p0, inv_p1;

  logic       code_ok;
  logic       lit;

  assign col         = pix_x_i[9:4];
  assign row         = pix_y_i[9:5];
  assign addr_next   = 10'(row) * 10'(COLS) + 10'(col);
  assign in_area     = active_i && ({4'b0, col} < 10'(COLS)) && ({5'b0, row} < 10'(ROWS));
  assign cursor_hit  = cursor_en_i && (col == cursor_col_i) && (row == {1'b0, cursor_row_i});
  assign frame_start = pix_valid_i && (pix_x_i == 10'd0) && (pix_y_i == 10'd0);

  glyph_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // Stage 1 -> 2: char_code_i arrives from the text buffer; ROM lookup is combinational.
  assign code_ok    = char_code_i < 5'(NUM_GLYPHS);
  assign rom_addr_o = code_ok ? {5'b0, char_code_i} : 10'd0;
  assign lit        = in_area_p1 && code_ok &&
                      (glyph_bit(rom_data_i, gx_p1, gy_p1) ^ inv_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      pix_valid_o <= 1'b0;
      char_addr_o <= 10'd0;
      rgb_o       <= BG_RGB;
    end else begin
      // Stage 0: address the text buffer; blink phase sampled pre-toggle.
      vld_p0 <= pix_valid_i;
      if (pix_valid_i && in_area) char_addr_o <= addr_next;
      // Stage 1
      vld_p1 <= vld_p0;
      // Stage 2
      pix_valid_o <= vld_p1;
      if (vld_p1) rgb_o <= lit ? FG_RGB : BG_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_valid_i) begin
      gx_p0      <= pix_x_i[3:0];
      gy_p0      <= pix_y_i[4:0];
      in_area_p0 <= in_area;
      inv_p0     <= cursor_hit && blink_phase;
    end
    if (vld_p0) begin
      gx_p1      <= gx_p0;
      gy_p1      <= gy_p0;
      in_area_p1 <= in_area_p0;
      inv_p1     <= inv_p0;
    end
  end

endmodule

// File: tb/tb_glyph_renderer.sv
// Self-checking bench for glyph_renderer with a behavioural text buffer,
// a glyph ROM array and a tile-level reference model.
module tb_glyph_renderer;
  import glyph_pkg::*;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
  localparam int BF = 2;
  localparam int NR = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pix_valid, active, cursor_en;
  logic [9:0]   pix_x, pix_y;
  logic [5:0]   cursor_col;
  logic [3:0]   cursor_row;
  logic [9:0]   char_addr, rom_addr;
  logic [4:0]   char_code = 5'd0;
  logic [511:0] rom_data;
  logic [11:0]  rgb;
  logic         pix_valid_out;

  logic [4:0]   tbuf [600];
  logic [511:0] rom  [32];
  int checks = 0, errors = 0, frames = 0;

  glyph_renderer #(
    .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF), .COLS(40), .ROWS(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid), .pix_x_i(pix_x),
    .pix_y_i(pix_y), .active_i(active), .cursor_col_i(cursor_col),
    .cursor_row_i(cursor_row), .cursor_en_i(cursor_en), .char_addr_o(char_addr),
    .char_code_i(char_code), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .rgb_o(rgb), .pix_valid_o(pix_valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) char_code <= tbuf[int'(char_addr)];
  assign rom_data = (rom_addr < 10'd32) ? rom[rom_addr[4:0]] : '0;

  task automatic drive(input logic v, input int x, input int y, input logic act);
    pix_valid = v;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    active    = act;
  endtask

  // Reference: tile lookup, glyph bit, cursor block inversion while blinking.
  function automatic logic [11:0] ref_pixel(input int x, input int y, input logic act);
    int col, row, gx, gy, code;
    logic lit;
    col = x / 16; row = y / 32; gx = x % 16; gy = y % 32;
    if (!act || col >= 40 || row >= 15) return BG;
    code = int'(tbuf[row * 40 + col]);
    if (code >= 27) return BG;
    lit = rom[code][gy * 16 + gx];
    if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && ((frames / BF) % 2 == 1))
      lit = !lit;
    return lit ? FG : BG;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    frames = 0;
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (rgb !== BG) begin errors++; $display("FAIL reset_rgb: got %h expected %h", rgb, BG); end
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid_out); end
    if (char_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", char_addr); end
  endtask

  task automatic test_glyph_a();
    logic [11:0] exp;
    int j;
    tbuf[0] = 5'd1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (i < 16) drive(1'b1, i, 31, 1'b1);
      else if (i < 32) drive(1'b1, i - 16, 2, 1'b1);
      else drive(1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
      if (i >= 2) begin
        j = i - 2;
        exp = (j < 16 && (j == 7 || j == 8)) ? FG : BG;
        checks += 2;
        if (pix_valid_out !== 1'b1) begin errors++; $display("FAIL a_valid[%0d]: got %b expected 1", j, pix_valid_out); end
        if (rgb !== exp) begin errors++; $display("FAIL a_rgb[%0d]: got %h expected %h", j, rgb, exp); end
      end
    end
  endtask

  task automatic test_glyph_h();
    tbuf[41] = 5'd8;
    @(negedge clk); drive(1'b1, 18, 40, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (char_addr !== 10'd41) begin errors++; $display("FAIL h_addr: got %0d expected 41", char_addr); end
    drive(1'b1, 16, 40, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    checks += 2;
    if (pix_valid_out !== 1'b1) begin errors++; $display("FAIL h_valid: got %b expected 1", pix_valid_out); end
    if (rgb !== FG) begin errors++; $display("FAIL h_rgb_lit: got %h expected %h", rgb, FG); end
    @(posedge clk); #1;
    checks++;
    if (rgb !== BG) begin errors++; $display("FAIL h_rgb_off: got %h expected %h", rgb, BG); end
    @(posedge clk); #1;
    checks += 2;
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL h_idle_valid: got %b expected 0", pix_valid_out); end
    if (rgb !== BG) begin errors++; $display("FAIL h_idle_hold: got %h expected %h", rgb, BG); end
  endtask

  task automatic test_bad_code_and_area();
    int sx[5] = '{18, 35, 650, 18, 18};
    int sy[5] = '{40, 5, 40, 40, 40};
    logic sa[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] se[5] = '{FG, BG, BG, BG, FG};
    tbuf[2] = 5'd29;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 5) drive(1'b1, sx[i], sy[i], sa[i]); else drive(1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
      if (i == 2) begin
        checks++;
        if (rom_addr !== 10'd0) begin errors++; $display("FAIL bad_rom_addr: got %0d expected 0", rom_addr); end
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (char_addr !== 10'd2) begin errors++; $display("FAIL hold_addr[%0d]: got %0d expected 2", i, char_addr); end
      end
      if (i >= 2) begin
        checks += 2;
        if (pix_valid_out !== 1'b1) begin errors++; $display("FAIL area_valid[%0d]: got %b expected 1", i - 2, pix_valid_out); end
        if (rgb !== se[i-2]) begin errors++; $display("FAIL area_rgb[%0d]: got %h expected %h", i - 2, rgb, se[i-2]); end
      end
    end
  endtask

  task automatic test_cursor_blink();
    int px[4] = '{0, 7, 15, 16};
    int py[4] = '{0, 9, 31, 0};
    logic [11:0] exp [20];
    int f, p, phase;
    do_reset();
    tbuf[0] = 5'd0; tbuf[1] = 5'd0;
    cursor_col = 6'd0; cursor_row = 4'd0; cursor_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      f = k / 4; p = k % 4;
      phase = (p == 0) ? (f / 2) % 2 : ((f + 1) / 2) % 2;
      exp[k] = (p != 3 && phase == 1) ? FG : BG;
    end
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i < 20) drive(1'b1, px[i%4], py[i%4], 1'b1); else drive(1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
      if (i >= 2) begin
        checks += 2;
        if (pix_valid_out !== 1'b1) begin errors++; $display("FAIL cur_valid[%0d]: got %b expected 1", i - 2, pix_valid_out); end
        if (rgb !== exp[i-2]) begin errors++; $display("FAIL cur_rgb[%0d]: got %h expected %h", i - 2, rgb, exp[i-2]); end
      end
    end
    frames = 5;
  endtask

  task automatic test_random();
    logic        ev [NR];
    logic [11:0] er [NR];
    logic [11:0] last;
    logic v, act;
    int x, y;
    last = BG;
    cursor_col = 6'($urandom % 40);
    cursor_row = 4'($urandom % 15);
    cursor_en  = 1'b1;
    for (int k = 0; k < 600; k++) tbuf[k] = 5'($urandom % 32);
    tbuf[int'(cursor_row) * 40 + int'(cursor_col)] = 5'($urandom % 27);
    for (int i = 0; i < NR + 2; i++) begin
      @(negedge clk);
      if (i < NR) begin
        v = ($urandom % 4) != 0;
        x = $urandom % 800; y = $urandom % 525;
        act = ($urandom % 8) != 0;
        if (i % 25 == 0) begin v = 1'b1; x = 0; y = 0; end
        drive(v, x, y, act);
        ev[i] = v;
        er[i] = ref_pixel(x, y, act);
        if (v && x == 0 && y == 0) frames++;
      end else drive(1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
      if (i >= 2) begin
        checks += 2;
        if (pix_valid_out !== ev[i-2]) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i - 2, pix_valid_out, ev[i-2]); end
        if (ev[i-2]) last = er[i-2];
        if (rgb !== last) begin errors++; $display("FAIL rnd_rgb[%0d]: got %h expected %h", i - 2, rgb, last); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    tbuf[41] = 5'd8;
    cursor_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(1'b1, 18, 40, 1'b1);
    end
    @(posedge clk); #1;
    checks++;
    if (pix_valid_out !== 1'b1 || rgb !== FG) begin errors++; $display("FAIL pre_rst: got %b/%h expected 1/%h", pix_valid_out, rgb, FG); end
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    #1;
    checks += 2;
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", pix_valid_out); end
    if (rgb !== BG) begin errors++; $display("FAIL rst_rgb: got %h expected %h", rgb, BG); end
    @(negedge clk);
    rst_n = 1'b1;
    frames = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL stale[%0d]: got %b expected 0", i, pix_valid_out); end
    end
    @(negedge clk); drive(1'b1, 18, 40, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 0, 0, 1'b0);
    checks++;
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL resume_early0: got %b expected 0", pix_valid_out); end
    @(posedge clk); #1;
    checks++;
    if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL resume_early1: got %b expected 0", pix_valid_out); end
    @(posedge clk); #1;
    checks += 2;
    if (pix_valid_out !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b expected 1", pix_valid_out); end
    if (rgb !== FG) begin errors++; $display("FAIL resume_rgb: got %h expected %h", rgb, FG); end
  endtask

  initial begin
    cursor_col = 6'd0; cursor_row = 4'd0; cursor_en = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 600; k++) tbuf[k] = 5'd0;
    for (int c = 0; c < 32; c++)
      for (int k = 0; k < GLYPH_BITS / 32; k++) rom[c][k*32 +: 32] = $urandom;
    rom[0]  = '0;
    rom[29] = '1;
    rom[1][31*16 +: 16] = 16'h0180;
    rom[1][2*16 +: 16]  = 16'h0000;
    rom[8][8*16 + 2]    = 1'b1;
    rom[8][8*16 + 0]    = 1'b0;

    test_reset();
    test_glyph_a();
    test_glyph_h();
    test_bad_code_and_area();
    test_cursor_blink();
    test_random();
    test_reset_midstream();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
